mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the maximum consecutive data grants while a fetch is pending.
REQ-002 SHALL have port clk, input, 1 bit: clock, all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port i_req, input, 1 bit: fetch request, held until i_rvalid.
REQ-005 SHALL have port i_addr, input, 32 bits: fetch address (PC).
REQ-006 SHALL have port i_flush, input, 1 bit: branch redirect, cancels the pending or outstanding fetch.
REQ-007 SHALL have port i_rvalid, output, 1 bit: one-cycle fetch response strobe.
REQ-008 SHALL have port i_rdata, output, 32 bits: fetched instruction.
REQ-009 SHALL have port d_req, input, 1 bit: load/store request, held until d_done.
REQ-010 SHALL have ports d_we (input, 1), d_addr (input, 32), d_wdata (input, 32) and d_wstrb (input, 4): data access controls.
REQ-011 SHALL have port d_done, output, 1 bit: one-cycle data completion strobe.
REQ-012 SHALL have port d_rdata, output, 32 bits: load data.
REQ-013 SHALL have ports m_req (output, 1), m_we (output, 1), m_addr (output, 32), m_wdata (output, 32) and m_wstrb (output, 4): shared memory request.
REQ-014 SHALL have ports m_gnt (input, 1), m_rvalid (input, 1) and m_rdata (input, 32): memory accept, response strobe (also write ack) and read data.
REQ-015 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-016 SHALL implement the states IDLE, ISSUE_I, ISSUE_D, WAIT_I and WAIT_D.
REQ-017 In IDLE, SHALL sample the requests; the winner's controls are registered into m_* and the state moves to ISSUE_x on the next edge. With no request, it stays in IDLE.
REQ-018 In IDLE, SHALL treat i_req as absent during any cycle in which i_flush is high.
REQ-019 Arbitration SHALL be as follows:
- d_req wins by default.
- i_req wins if starve_cnt == STARVE_LIMIT.
- A single requester always wins.
REQ-020 starve_cnt SHALL behave as follows:
- Increments, saturating at STARVE_LIMIT, on each D grant while i_req is high.
- Clears on an I grant.
- Clears on any IDLE cycle in which i_req is low.
REQ-021 In ISSUE_x, SHALL hold m_req=1 with all m_* signals stable until m_gnt=1, then move to WAIT_x.
REQ-022 An I grant SHALL drive m_we=0, m_wstrb=0 and m_wdata=0.
REQ-023 In WAIT_x, SHALL hold m_req=0. On m_rvalid=1 it returns to IDLE on the same edge.
REQ-024 In WAIT_D with m_rvalid, SHALL drive d_done=1 and d_rdata=m_rdata combinationally in that cycle.
REQ-025 In WAIT_I with m_rvalid and kill=0 and i_flush=0, SHALL drive i_rvalid=1 and i_rdata=m_rdata combinationally.
REQ-026 Minimum request-to-response latency SHALL be 2 cycles: request in IDLE at cycle 0, m_gnt at cycle 1, m_rvalid at cycle 2, strobe at cycle 2.
REQ-027 Back-to-back: a requester SHALL be able to change its request at the edge ending its strobe, and IDLE arbitrates it next cycle.
REQ-028 kill SHALL be set by i_flush=1 in ISSUE_I or in WAIT_I without m_rvalid. The transaction still completes on the memory side, but i_rvalid is suppressed. kill clears on return to IDLE.
REQ-029 i_flush in the same cycle as m_rvalid in WAIT_I SHALL suppress i_rvalid.
REQ-030 i_flush SHALL have no effect on a D transaction.
REQ-031 SHALL ignore m_gnt outside ISSUE_x and m_rvalid outside WAIT_x.
REQ-032 Outside their strobe cycles, i_rdata and d_rdata SHALL be 0, and i_rvalid and d_done SHALL be 0.
REQ-033 Only one memory transaction SHALL be outstanding at any time.

Reset
REQ-034 On rst_n=0, SHALL immediately (asynchronously) set:
- state=IDLE;
- m_req, m_we, m_addr, m_wdata and m_wstrb to 0;
- starve_cnt=0 and kill=0;
- busy=0;
- i_rvalid, d_done, i_rdata and d_rdata to 0.
REQ-035 Reset mid-transaction SHALL abandon the transaction with no strobe. A late m_rvalid after reset is ignored in IDLE.
REQ-036 The first arbitration SHALL occur in the first cycle with rst_n=1.

Verification
REQ-037 Bench SHALL cover fetch only: i_req=1, i_addr=0x0, m_gnt tied to 1, m_rvalid one cycle after gnt, m_rdata=0x00500093 -> i_rvalid at cycle 2 with i_rdata=0x00500093, and m_req high exactly 1 cycle.
REQ-038 Bench SHALL cover a conflict: i_req and d_req high together, d_addr=0x100 -> D granted first (m_addr=0x100), then I (m_addr=i_addr).
REQ-039 Bench SHALL cover starvation: d_req high continuously, i_req high, STARVE_LIMIT=4 -> 4 D grants, then 1 I grant, then D resumes.
REQ-040 Bench SHALL cover a flush: i_flush pulsed in WAIT_I, m_rvalid 3 cycles later -> no i_rvalid, and the FSM returns to IDLE.
REQ-041 Bench SHALL cover a write: d_we=1, d_wstrb=0xF, d_wdata=0xDEADBEEF, m_gnt delayed 2 cycles -> m_* stable across the wait, and d_done when m_rvalid arrives.
REQ-042 Bench SHALL cover reset: rst_n asserted in WAIT_D -> all outputs 0 immediately, and a later m_rvalid produces no d_done.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a load/store port onto one shared
// request/grant/response memory port, with one transaction outstanding at a time.
//
// state   | meaning
// IDLE    | sample both requesters and register the winner onto m_*
// ISSUE_I | fetch presented on m_*, waiting for m_gnt
// ISSUE_D | data access presented on m_*, waiting for m_gnt
// WAIT_I  | fetch accepted, waiting for m_rvalid (kill drops the strobe)
// WAIT_D  | data access accepted, waiting for m_rvalid
module mem_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   input  logic        i_flush,
   output logic        i_rvalid,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wstrb,
   output logic        d_done,
   output logic [31:0] d_rdata,
   output logic        m_req,
   output logic        m_we,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_wstrb,
   input  logic        m_gnt,
   input  logic        m_rvalid,
   input  logic [31:0] m_rdata,
   output logic        busy
);

   localparam int unsigned CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ISSUE_I = 3'd1,
      ISSUE_D = 3'd2,
      WAIT_I  = 3'd3,
      WAIT_D  = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic          m_req_q, m_req_d;
   logic          m_we_q, m_we_d;
   logic [31:0]   m_addr_q, m_addr_d;
   logic [31:0]   m_wdata_q, m_wdata_d;
   logic [3:0]    m_wstrb_q, m_wstrb_d;
   logic [CW-1:0] starve_q, starve_d;
   logic          kill_q, kill_d;

   logic          i_vld;
   logic          pick_i;
   logic          pick_d;

   // A fetch raised in the same cycle as a redirect is stale and does not compete.
   assign i_vld  = i_req && !i_flush;
   assign pick_i = i_vld && (!d_req || (starve_q == LIMIT));
   assign pick_d = d_req && !pick_i;

   always_comb begin
      state_d   = state_q;
      m_req_d   = m_req_q;
      m_we_d    = m_we_q;
      m_addr_d  = m_addr_q;
      m_wdata_d = m_wdata_q;
      m_wstrb_d = m_wstrb_q;
      starve_d  = starve_q;
      kill_d    = kill_q;

      case (state_q)
         IDLE: begin
            kill_d = 1'b0;
            if (pick_i) begin
               state_d   = ISSUE_I;
               m_req_d   = 1'b1;
               m_we_d    = 1'b0;
               m_addr_d  = i_addr;
               m_wdata_d = '0;
               m_wstrb_d = '0;
               starve_d  = '0;
            end else if (pick_d) begin
               state_d   = ISSUE_D;
               m_req_d   = 1'b1;
               m_we_d    = d_we;
               m_addr_d  = d_addr;
               m_wdata_d = d_wdata;
               m_wstrb_d = d_wstrb;
               if (!i_vld) begin
                  starve_d = '0;
               end else if (starve_q != LIMIT) begin
                  starve_d = starve_q + CW'(1);
               end
            end else if (!i_vld) begin
               starve_d = '0;
            end
         end
         ISSUE_I: begin
            if (i_flush) begin
               kill_d = 1'b1;
            end
            if (m_gnt) begin
               state_d = WAIT_I;
               m_req_d = 1'b0;
            end
         end
         ISSUE_D: begin
            if (m_gnt) begin
               state_d = WAIT_D;
               m_req_d = 1'b0;
            end
         end
         WAIT_I: begin
            if (m_rvalid) begin
               state_d = IDLE;
               kill_d  = 1'b0;
            end else if (i_flush) begin
               kill_d = 1'b1;
            end
         end
         WAIT_D: begin
            if (m_rvalid) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            m_req_d = 1'b0;
            kill_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         m_req_q   <= 1'b0;
         m_we_q    <= 1'b0;
         m_addr_q  <= '0;
         m_wdata_q <= '0;
         m_wstrb_q <= '0;
         starve_q  <= '0;
         kill_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         m_req_q   <= m_req_d;
         m_we_q    <= m_we_d;
         m_addr_q  <= m_addr_d;
         m_wdata_q <= m_wdata_d;
         m_wstrb_q <= m_wstrb_d;
         starve_q  <= starve_d;
         kill_q    <= kill_d;
      end
   end

   assign m_req   = m_req_q;
   assign m_we    = m_we_q;
   assign m_addr  = m_addr_q;
   assign m_wdata = m_wdata_q;
   assign m_wstrb = m_wstrb_q;
   assign busy    = (state_q != IDLE);

   // Response strobes pass m_rdata straight through in the response cycle only.
   assign d_done   = (state_q == WAIT_D) && m_rvalid;
   assign d_rdata  = d_done ? m_rdata : '0;
   assign i_rvalid = (state_q == WAIT_I) && m_rvalid && !kill_q && !i_flush;
   assign i_rdata  = i_rvalid ? m_rdata : '0;

endmodule
